// File: rtl/riscv_mmio_pkg.sv
// Shared constants and helpers for the riscv MMIO GPIO / cycle-counter responder.
package riscv_mmio_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = 4;

  localparam int unsigned OFF_OUT   = 'h00;
  localparam int unsigned OFF_SET   = 'h04;
  localparam int unsigned OFF_CLR   = 'h08;
  localparam int unsigned OFF_TGL   = 'h0C;
  localparam int unsigned OFF_IN    = 'h10;
  localparam int unsigned OFF_CYCLE = 'h14;
  localparam int unsigned OFF_BLINK = 'h18;

  // Replace only the strobed bytes of old_w with the matching bytes of new_w.
  function automatic logic [BUS_DATA_W-1:0] strb_merge(
    input logic [BUS_DATA_W-1:0] old_w,
    input logic [BUS_DATA_W-1:0] new_w,
    input logic [BUS_STRB_W-1:0] strb
  );
    logic [BUS_DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BUS_STRB_W; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/riscv_sync_bus.sv
// Multi-bit, per-bit independent flop-chain synchronizer for asynchronous pin inputs.
module riscv_sync_bus #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= {stage_q[STAGES-2:0], async_i};
  end

  assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/riscv_mmio_gpio.sv
// MMIO GPIO + free-running cycle counter responder on the core data bus.
// Define GPIO_BLINK_EN to add the BLINK register and its 24-bit blink prescaler.
module riscv_mmio_gpio
  import riscv_mmio_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int NUM_OUT     = 4,
  parameter int NUM_IN      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [BUS_DATA_W-1:0] req_wdata,
  input  logic [BUS_STRB_W-1:0] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BUS_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [NUM_OUT-1:0]    gpio_out,
  input  logic [NUM_IN-1:0]     gpio_in
);

`ifdef GPIO_BLINK_EN
  localparam int unsigned MAP_END = 'h1C;
`else
  localparam int unsigned MAP_END = 'h18;
`endif

  logic [NUM_OUT-1:0]    out_q, out_d;
  logic [BUS_DATA_W-1:0] cycle_q, cycle_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [BUS_DATA_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [NUM_IN-1:0]     in_sync;
  logic                  accept, bad_addr;
  logic [NUM_OUT-1:0]    strb_bits, out_wr;

  riscv_sync_bus #(.WIDTH(NUM_IN), .STAGES(SYNC_STAGES)) u_in_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (gpio_in),
    .sync_o  (in_sync)
  );

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign bad_addr  = (|req_addr[1:0]) || (req_addr >= ADDR_W'(MAP_END));
  // SET/CLR/TGL see unstrobed bytes as zero; OUT sees them as unchanged.
  assign strb_bits = NUM_OUT'(strb_merge('0, req_wdata, req_wstrb));
  assign out_wr    = NUM_OUT'(strb_merge(BUS_DATA_W'(out_q), req_wdata, req_wstrb));

`ifdef GPIO_BLINK_EN
  logic [NUM_OUT-1:0] blink_q, blink_d;
  logic [23:0]        presc_q;
  logic               phase_q;
`endif

  always_comb begin
    out_d       = out_q;
    cycle_d     = cycle_q + 32'd1;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef GPIO_BLINK_EN
    blink_d     = blink_q;
`endif
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
    if (accept) begin
      rsp_valid_d = 1'b1;
      err_d       = bad_addr;
      rdata_d     = '0;
      if (!bad_addr) begin
        case (req_addr)
          ADDR_W'(OFF_OUT):   if (req_we) out_d = out_wr; else rdata_d = BUS_DATA_W'(out_q);
          ADDR_W'(OFF_SET):   if (req_we) out_d = out_q | strb_bits;
          ADDR_W'(OFF_CLR):   if (req_we) out_d = out_q & ~strb_bits;
          ADDR_W'(OFF_TGL):   if (req_we) out_d = out_q ^ strb_bits;
          ADDR_W'(OFF_IN):    if (!req_we) rdata_d = BUS_DATA_W'(in_sync);
          // Reads report the count the register takes on at this acceptance edge.
          ADDR_W'(OFF_CYCLE): if (req_we) cycle_d = strb_merge(cycle_q, req_wdata, req_wstrb);
                              else rdata_d = cycle_q + 32'd1;
`ifdef GPIO_BLINK_EN
          ADDR_W'(OFF_BLINK): if (req_we) blink_d = NUM_OUT'(strb_merge(BUS_DATA_W'(blink_q), req_wdata, req_wstrb));
                              else rdata_d = BUS_DATA_W'(blink_q);
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      cycle_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      cycle_q     <= cycle_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

`ifdef GPIO_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
      presc_q <= '0;
      phase_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      presc_q <= presc_q + 24'd1;
      if (presc_q == 24'hFF_FFFF) phase_q <= !phase_q;
    end
  end

  assign gpio_out = out_q & ~(blink_q & {NUM_OUT{phase_q}});
`else
  assign gpio_out = out_q;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
